// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//   FWD_*    : forwarding-select encodings for one EX operand
//   stage_t  : one in-flight pipeline stage entry (EX, MEM or WB)
//   action_t : which pipeline action the controller applies this cycle
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Widest register address a stage entry can carry; narrower
  // configurations zero-extend into the rd field.
  localparam int RD_MAX = 8;

  typedef struct packed {
    logic              valid;
    logic [RD_MAX-1:0] rd;
    logic              rw;    // writes the register file
    logic              mr;    // load
    logic              ma;    // memory access (load or store)
  } stage_t;

  // Priority order, highest first: MEM_STALL, BRANCH, LOAD_USE, NORMAL.
  typedef enum logic [1:0] {
    ACT_NORMAL    = 2'd0,
    ACT_LOAD_USE  = 2'd1,
    ACT_BRANCH    = 2'd2,
    ACT_MEM_STALL = 2'd3
  } action_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline (master) and the hazard controller (slave).
//   Inputs to the controller : ID instruction fields, EX branch outcome,
//                              data-memory ready, stall-counter clear.
//   Outputs of the controller: pipeline-register enables/bubbles/flush,
//                              per-operand forwarding selects, stall counter.
// Handshake: the memory op held in MEM completes on the first cycle that
// mem_ready=1; until then MEM and EX hold their contents and the controller
// stalls everything upstream. mem_ready is ignored when MEM holds no memory op.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_acc;
  logic                      ex_br_taken;
  logic                      mem_ready;
  logic                      cnt_clr;

  logic                      pc_write;
  logic                      if_id_write;
  logic                      if_id_flush;
  logic                      id_ex_bubble;
  logic                      ex_mem_hold;
  logic                      mem_wb_bubble;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_rs, id_src_used, id_rd, id_reg_write, id_mem_read,
           id_mem_acc, ex_br_taken, mem_ready, cnt_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
           mem_wb_bubble, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_src_used, id_rd, id_reg_write, id_mem_read,
           id_mem_acc, ex_br_taken, mem_ready, cnt_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
           mem_wb_bubble, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for a single EX source operand.
//   ex_rs/ex_used : operand register and whether EX actually reads it
//   mem_ok/mem_rd : MEM holds a forwardable (non-load) register write to mem_rd
//   wb_ok/wb_rd   : WB holds a register write to wb_rd
//   sel           : FWD_MEM, FWD_WB or FWD_RF
module fwd_sel_unit import pipe_pkg::*; #(
  parameter int REG_AW   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic              ex_used,
  input  logic              mem_ok,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_ok,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);
  logic rs_zero;
  assign rs_zero = ZERO_REG && (ex_rs == '0);

  // MEM is checked first: it carries the younger value of the register.
  always_comb begin
    sel = FWD_RF;
    if (ex_used && !rs_zero) begin
      if (mem_ok && (mem_rd == ex_rs)) begin
        sel = FWD_MEM;
      end else if (wb_ok && (wb_rd == ex_rs)) begin
        sel = FWD_WB;
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// Tracks EX/MEM/WB destination entries and decides, each cycle, between a
// memory-wait stall, a taken-branch flush, a load-use stall or normal flow.
//   clk, rst : rising-edge clock, asynchronous active-low reset
//   bus      : slave side of pipe_hazard_ctrl_if (ID fields, branch, memory
//              ready, counter clear in; pipeline controls, fwd_sel, stall_cnt out)
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  stage_t                    ex_q, mem_q, wb_q;
  logic [NUM_SRC*REG_AW-1:0] ex_rs_q;
  logic [NUM_SRC-1:0]        ex_used_q;
  logic                      br_pend_q;
  logic [CNT_W-1:0]          cnt_q;

  stage_t  id_entry;
  action_t act;
  logic    mem_stall, branch, load_use;
  logic    pc_write, if_id_write, if_id_flush;
  logic    id_ex_bubble, ex_mem_hold, mem_wb_bubble;
  logic [NUM_SRC*2-1:0] fwd_sel;

  // Entry e writes register r, with register 0 excluded when it is hardwired.
  function automatic logic hit(input stage_t e, input logic [REG_AW-1:0] r);
    hit = e.valid && e.rw && (e.rd == RD_MAX'(r)) && !(ZERO_REG && (r == '0));
  endfunction

  always_comb begin
    id_entry       = '0;
    id_entry.valid = bus.id_valid;
    id_entry.rd    = RD_MAX'(bus.id_rd);
    id_entry.rw    = bus.id_reg_write;
    id_entry.mr    = bus.id_mem_read;
    id_entry.ma    = bus.id_mem_acc;
  end

  assign mem_stall = mem_q.valid && mem_q.ma && !bus.mem_ready;

  // A branch seen during a memory wait is remembered in br_pend_q because the
  // pipeline may drop ex_br_taken while EX is frozen.
  assign branch = ex_q.valid && (bus.ex_br_taken || br_pend_q);

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] && hit(ex_q, bus.id_rs[i*REG_AW +: REG_AW])) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && bus.id_valid && ex_q.mr;
  end

  always_comb begin
    if (mem_stall) begin
      act = ACT_MEM_STALL;
    end else if (branch) begin
      act = ACT_BRANCH;
    end else if (load_use) begin
      act = ACT_LOAD_USE;
    end else begin
      act = ACT_NORMAL;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    case (act)
      ACT_MEM_STALL: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      ACT_BRANCH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ACT_LOAD_USE: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_rs_q   <= '0;
      ex_used_q <= '0;
      br_pend_q <= 1'b0;
    end else begin
      case (act)
        ACT_MEM_STALL: begin
          // EX and MEM freeze; the WB write has already retired.
          wb_q      <= '0;
          br_pend_q <= br_pend_q || (bus.ex_br_taken && ex_q.valid);
        end
        ACT_BRANCH, ACT_LOAD_USE: begin
          ex_q      <= '0;
          ex_used_q <= '0;
          mem_q     <= ex_q;
          wb_q      <= mem_q;
          br_pend_q <= 1'b0;
        end
        default: begin
          ex_q      <= id_entry;
          ex_rs_q   <= bus.id_rs;
          ex_used_q <= bus.id_src_used & {NUM_SRC{bus.id_valid}};
          mem_q     <= ex_q;
          wb_q      <= mem_q;
          br_pend_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (!pc_write && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A load in MEM is never a forward source; load_use keeps its consumer
  // out of EX until the load reaches WB.
  logic mem_fwd_ok, wb_fwd_ok;
  assign mem_fwd_ok = mem_q.valid && mem_q.rw && !mem_q.mr;
  assign wb_fwd_ok  = wb_q.valid && wb_q.rw;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_sel_unit #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd (
      .ex_rs   (ex_rs_q[g*REG_AW +: REG_AW]),
      .ex_used (ex_used_q[g] && ex_q.valid),
      .mem_ok  (mem_fwd_ok),
      .mem_rd  (mem_q.rd[REG_AW-1:0]),
      .wb_ok   (wb_fwd_ok),
      .wb_rd   (wb_q.rd[REG_AW-1:0]),
      .sel     (fwd_sel[g*2 +: 2])
    );
  end

  // WB load/access flags and the zero-extension bits of rd are carried only
  // to keep every stage entry the same shape.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{wb_q, mem_q.rd};

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.ex_mem_hold   = ex_mem_hold;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.fwd_sel       = fwd_sel;
  assign bus.stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: an instruction-level pipeline model
// predicts every output each cycle, and hand-computed literals queued in
// exp_q pin the model at the interesting points of each scenario.
module tb_pipe_hazard_ctrl;

  localparam int AW = 4;
  localparam int NS = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, want);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act);
    logic [15:0] want;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=<none queued>", name, $time, act);
    end else begin
      want = exp_q.pop_front();
      chk(name, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One record per in-flight instruction; the three slots are the
  // instructions currently sitting in EX, MEM and WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    bit ma;
    int rs[NS];
    bit used[NS];
  } ins_t;

  ins_t empty_ins;
  ins_t m_ex, m_mem, m_wb;
  bit   m_pend;
  int   m_cnt;

  function automatic bit writes(input ins_t e, input int r);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  function automatic ins_t cur_id();
    ins_t e;
    e.v  = bus.id_valid;
    e.rd = int'(bus.id_rd);
    e.rw = bus.id_reg_write;
    e.mr = bus.id_mem_read;
    e.ma = bus.id_mem_acc;
    for (int i = 0; i < NS; i++) begin
      e.rs[i]   = int'(bus.id_rs[i*AW +: AW]);
      e.used[i] = bus.id_src_used[i] && bus.id_valid;
    end
    return e;
  endfunction

  // 3 = waiting on memory, 2 = branch flush, 1 = load-use stall, 0 = flow
  function automatic int decide();
    ins_t id;
    id = cur_id();
    if (m_mem.v && m_mem.ma && !bus.mem_ready) return 3;
    if (m_ex.v && (bus.ex_br_taken || m_pend)) return 2;
    for (int i = 0; i < NS; i++)
      if (id.v && id.used[i] && m_ex.mr && writes(m_ex, id.rs[i])) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    int d;
    if (!rst) begin
      m_ex = empty_ins; m_mem = empty_ins; m_wb = empty_ins;
      m_pend = 1'b0; m_cnt = 0;
    end else begin
      d = decide();
      if (bus.cnt_clr) m_cnt = 0;
      else if ((d == 1 || d == 3) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (d == 3) begin
        m_wb   = empty_ins;
        m_pend = m_pend || (bus.ex_br_taken && m_ex.v);
      end else begin
        m_wb   = m_mem;
        m_mem  = m_ex;
        m_ex   = (d == 0) ? cur_id() : empty_ins;
        m_pend = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int d;
    int r;
    logic [5:0] ec;
    logic [NS*2-1:0] ef;
    logic illegal;
    d = decide();
    case (d)
      3:       ec = 6'b000011;
      2:       ec = 6'b111100;
      1:       ec = 6'b000100;
      default: ec = 6'b110000;
    endcase
    ef = '0;
    illegal = 1'b0;
    for (int i = 0; i < NS; i++) begin
      r = m_ex.rs[i];
      if (m_ex.v && m_ex.used[i]) begin
        if (writes(m_mem, r) && m_mem.mr) illegal = 1'b1;
        if (writes(m_mem, r) && !m_mem.mr) ef[i*2 +: 2] = 2'b10;
        else if (writes(m_wb, r))          ef[i*2 +: 2] = 2'b01;
      end
    end
    chk("ctrl", 16'({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                     bus.ex_mem_hold, bus.mem_wb_bubble}), 16'(ec));
    chk("fwd_sel", 16'(bus.fwd_sel), 16'(ef));
    chk("stall_cnt", 16'(bus.stall_cnt), 16'(m_cnt));
    chk("no_fwd_from_load_in_mem", 16'(illegal), 16'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input bit v, input int rd, input int rs0, input int rs1,
                         input logic [1:0] used, input bit rw, input bit mr, input bit ma);
    bus.id_valid     = v;
    bus.id_rd        = AW'(rd);
    bus.id_rs        = {AW'(rs1), AW'(rs0)};
    bus.id_src_used  = used;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_acc   = ma;
  endtask

  task automatic nop();                            set_ins(0, 0, 0, 0, 2'b00, 0, 0, 0); endtask
  task automatic alu(input int rd, a, b);          set_ins(1, rd, a, b, 2'b11, 1, 0, 0); endtask
  task automatic lw(input int rd, a);              set_ins(1, rd, a, 0, 2'b01, 1, 1, 1); endtask
  task automatic br_ins(input int a, b);           set_ins(1, 0, a, b, 2'b11, 0, 0, 0); endtask

  // ---------------- directed stimulus ----------------
  initial begin
    nop();
    bus.ex_br_taken = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.cnt_clr     = 1'b0;

    // Reset state
    exp_q.push_back(16'd1); exp_q.push_back(16'd1); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    repeat (2) @(posedge clk);
    #1;
    lit("rst_pc_write", 16'(bus.pc_write));
    lit("rst_if_id_write", 16'(bus.if_id_write));
    lit("rst_fwd_sel", 16'(bus.fwd_sel));
    lit("rst_stall_cnt", 16'(bus.stall_cnt));
    rst = 1'b1;
    tick();

    // ALU chain: back-to-back -> MEM, one gap -> WB, two writers -> MEM wins
    exp_q.push_back(16'h2); exp_q.push_back(16'h1); exp_q.push_back(16'ha);
    alu(3, 1, 2); tick();
    alu(4, 3, 1); tick();
    nop(); #1 lit("alu_fwd_mem", 16'(bus.fwd_sel));
    tick();
    alu(3, 1, 2); tick();
    alu(7, 8, 9); tick();
    alu(4, 3, 1); tick();
    nop(); #1 lit("alu_fwd_wb", 16'(bus.fwd_sel));
    tick();
    alu(3, 1, 2); tick();
    alu(3, 5, 6); tick();
    alu(4, 3, 3); tick();
    nop(); #1 lit("alu_fwd_youngest", 16'(bus.fwd_sel));

    // Load-use
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd1);
    exp_q.push_back(16'h1); exp_q.push_back(16'd1);
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    lw(2, 1); tick();
    alu(5, 2, 6); #1;
    lit("lu_pc_write", 16'(bus.pc_write));
    lit("lu_id_ex_bubble", 16'(bus.id_ex_bubble));
    tick();
    #1 lit("lu_resume_pc_write", 16'(bus.pc_write));
    tick();
    nop(); #1;
    lit("lu_fwd_wb", 16'(bus.fwd_sel));
    lit("lu_stall_cnt", 16'(bus.stall_cnt));

    // Memory wait of three cycles
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'd1); exp_q.push_back(16'd1);
    end
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd3);
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    lw(2, 1); tick();
    nop(); tick();
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      lit("mw_ex_mem_hold", 16'(bus.ex_mem_hold));
      lit("mw_mem_wb_bubble", 16'(bus.mem_wb_bubble));
      tick();
    end
    bus.mem_ready = 1'b1; #1;
    lit("mw_release_hold", 16'(bus.ex_mem_hold));
    lit("mw_release_pc_write", 16'(bus.pc_write));
    lit("mw_stall_cnt", 16'(bus.stall_cnt));
    tick();

    // Branch during memory wait: deferred, then a single flush
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    exp_q.push_back(16'd1); exp_q.push_back(16'd1); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    nop(); tick();
    lw(2, 1); tick();
    br_ins(3, 4); tick();
    lw(11, 1);
    bus.mem_ready = 1'b0; bus.ex_br_taken = 1'b1; #1;
    lit("br_stall_no_flush", 16'(bus.if_id_flush));
    lit("br_stall_hold", 16'(bus.ex_mem_hold));
    tick();
    bus.ex_br_taken = 1'b0; #1;
    lit("br_pending_no_flush", 16'(bus.if_id_flush));
    tick();
    bus.mem_ready = 1'b1; #1;
    lit("br_release_flush", 16'(bus.if_id_flush));
    lit("br_release_bubble", 16'(bus.id_ex_bubble));
    tick();
    alu(12, 11, 11); #1;
    lit("br_squashed_load_no_stall", 16'(bus.pc_write));
    lit("br_no_second_flush", 16'(bus.if_id_flush));
    tick();

    // Register 0 never forwards or stalls
    exp_q.push_back(16'h0); exp_q.push_back(16'd1);
    alu(0, 1, 2); tick();
    alu(5, 0, 0); tick();
    nop(); #1 lit("r0_no_fwd", 16'(bus.fwd_sel));
    lw(0, 1); tick();
    alu(5, 0, 0); #1 lit("r0_no_load_use", 16'(bus.pc_write));
    tick();

    // Counter saturation and clear
    exp_q.push_back(16'd15); exp_q.push_back(16'd0);
    nop(); bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    lw(2, 1); tick();
    nop(); tick();
    bus.mem_ready = 1'b0;
    repeat (20) tick();
    bus.mem_ready = 1'b1; #1;
    lit("sat_stall_cnt", 16'(bus.stall_cnt));
    tick();
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0; #1;
    lit("clr_stall_cnt", 16'(bus.stall_cnt));
    tick();

    // Asynchronous reset with a deferred branch outstanding
    exp_q.push_back(16'd1); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    lw(2, 1); tick();
    br_ins(3, 4); tick();
    nop(); bus.mem_ready = 1'b0; bus.ex_br_taken = 1'b1; tick();
    bus.ex_br_taken = 1'b0; #1;
    lit("ar_pre_hold", 16'(bus.ex_mem_hold));
    rst = 1'b0; #1;
    lit("ar_pc_write", 16'(bus.pc_write));
    lit("ar_hold", 16'(bus.ex_mem_hold));
    lit("ar_stall_cnt", 16'(bus.stall_cnt));
    rst = 1'b1; bus.mem_ready = 1'b1; #1;
    lit("ar_no_pending_flush", 16'(bus.if_id_flush));

    repeat (3) tick();
    chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
